// File: rtl/pix_serializer_if.sv
// Pixel serializer bus: video word load, palette/control write port,
// flag clear, and the pixel/colour/status outputs.
// With PIX_SERIALIZER_PALETTE_EN defined, the bus also carries the LUT write port.
//
// Handshake: pal_we is a level request. The slave captures pal_din on every
// rising edge where pal_we is high, and raises pal_ack one cycle later. The
// master holds pal_we and pal_din stable until it sees pal_ack, then drops
// pal_we. pal_ack falls on the cycle after pal_we drops. load, flag_clr and
// lut_we are single-cycle strobes with no reply.
interface pix_serializer_if #(
  parameter int WORD_W   = 16,
  parameter int BPP      = 2,
  parameter int PAL_BITS = 4
);
  logic                load;
  logic [WORD_W-1:0]   word;
  logic                pal_we;
  logic [PAL_BITS:0]   pal_din;
  logic                pal_ack;
  logic                irq_en;
  logic                flag_clr;
  logic [BPP-1:0]      pix;
  logic [3:0]          rgbi;
  logic                empty;
  logic                underrun;
  logic                overrun;
  // Debug view of the palette code currently applied to the pixels
  logic [PAL_BITS-1:0] pal_cur;
`ifdef PIX_SERIALIZER_PALETTE_EN
  logic                    lut_we;
  logic [PAL_BITS+BPP-1:0] lut_addr;
  logic [3:0]              lut_data;

  modport master (
    output load, word, pal_we, pal_din, flag_clr, lut_we, lut_addr, lut_data,
    input  pal_ack, irq_en, pix, rgbi, empty, underrun, overrun, pal_cur
  );
  modport slave (
    input  load, word, pal_we, pal_din, flag_clr, lut_we, lut_addr, lut_data,
    output pal_ack, irq_en, pix, rgbi, empty, underrun, overrun, pal_cur
  );
`else
  modport master (
    output load, word, pal_we, pal_din, flag_clr,
    input  pal_ack, irq_en, pix, rgbi, empty, underrun, overrun, pal_cur
  );
  modport slave (
    input  load, word, pal_we, pal_din, flag_clr,
    output pal_ack, irq_en, pix, rgbi, empty, underrun, overrun, pal_cur
  );
`endif
endinterface

// File: rtl/pix_serializer.sv
// Pixel serializer: takes a video word on load and shifts out BPP-bit pixels,
// pixel 0 (LSBs) first, one per pin_clk. It tracks underrun (pixel due while
// empty) and overrun (word replaced before fully shown) as sticky flags, and
// switches the palette code only on word boundaries to avoid tearing.
// Optional feature macro: PIX_SERIALIZER_PALETTE_EN selects a writable colour
// LUT indexed by {palette, pixel}; otherwise a fixed per-BPP colour map is used.
module pix_serializer #(
  parameter int WORD_W   = 16,
  parameter int BPP      = 2,
  parameter int PAL_BITS = 4
) (
  input logic             pin_clk,
  input logic             pin_rst,
  pix_serializer_if.slave bus
);
  localparam int PPW   = WORD_W / BPP;
  localparam int REM_W = $clog2(PPW + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(PPW - 1);

  logic [WORD_W-1:0]   shreg;
  logic [REM_W-1:0]    rem;
  logic                empty_q;
  logic                armed_q;
  logic                underrun_q;
  logic                overrun_q;
  logic [PAL_BITS-1:0] pal_pend;
  logic [PAL_BITS-1:0] pal_cur;
  logic                irq_en_q;
  logic                pal_ack_q;
  logic [BPP-1:0]      pix_w;
  logic [3:0]          color;
  logic                underrun_set;
  logic                overrun_set;

  // A pixel falls due with nothing to show only once a word has ever been loaded
  assign underrun_set = !bus.load && (rem == '0) && armed_q;
  assign overrun_set  = bus.load && (rem != '0);

  // Shifter: load wins over shifting; exhausted shifter refills with ones
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      shreg   <= '1;
      rem     <= '0;
      empty_q <= 1'b1;
      armed_q <= 1'b0;
    end else if (bus.load) begin
      shreg   <= bus.word;
      rem     <= REM_LOAD;
      empty_q <= 1'b0;
      armed_q <= 1'b1;
    end else if (rem != '0) begin
      shreg <= {{BPP{1'b1}}, shreg[WORD_W-1:BPP]};
      rem   <= rem - REM_W'(1);
    end else begin
      shreg   <= '1;
      empty_q <= 1'b1;
    end
  end

  // Sticky status flags: a new event in the same cycle as flag_clr keeps the flag set
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_set || (underrun_q && !bus.flag_clr);
      overrun_q  <= overrun_set  || (overrun_q  && !bus.flag_clr);
    end
  end

  // Palette/control register; the active code only changes at a word load,
  // taking a same-cycle write directly so the new word sees the new code
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      pal_pend  <= '1;
      pal_cur   <= '1;
      irq_en_q  <= 1'b1;
      pal_ack_q <= 1'b0;
    end else begin
      pal_ack_q <= bus.pal_we;
      if (bus.pal_we) begin
        pal_pend <= bus.pal_din[PAL_BITS-1:0];
        irq_en_q <= bus.pal_din[PAL_BITS];
      end
      if (bus.load) begin
        pal_cur <= bus.pal_we ? bus.pal_din[PAL_BITS-1:0] : pal_pend;
      end
    end
  end

  assign pix_w = shreg[BPP-1:0];

`ifdef PIX_SERIALIZER_PALETTE_EN
  logic [3:0] lut_mem [0:(1 << (PAL_BITS + BPP)) - 1];

  // Colour LUT write port; contents survive reset
  always_ff @(posedge pin_clk) begin
    if (bus.lut_we) begin
      lut_mem[bus.lut_addr] <= bus.lut_data;
    end
  end

  assign color = lut_mem[{pal_cur, pix_w}];
`else
  // Fixed colour map; the palette code does not affect colour in this build
  generate
    if (BPP == 4) begin : g_map4
      assign color = 4'(pix_w);
    end else if (BPP == 1) begin : g_map1
      assign color = pix_w[0] ? 4'hF : 4'h0;
    end else begin : g_map2
      // Two-bit codes map to black, blue, green, red
      always_comb begin
        color = 4'h0;
        case (pix_w[1:0])
          2'd0:    color = 4'h0;
          2'd1:    color = 4'h2;
          2'd2:    color = 4'h4;
          default: color = 4'h8;
        endcase
      end
    end
  endgenerate
`endif

  assign bus.pix      = pix_w;
  assign bus.rgbi     = empty_q ? 4'h0 : color;
  assign bus.empty    = empty_q;
  assign bus.underrun = underrun_q;
  assign bus.overrun  = overrun_q;
  assign bus.irq_en   = irq_en_q;
  assign bus.pal_ack  = pal_ack_q;
  assign bus.pal_cur  = pal_cur;
endmodule
